// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and opcode helpers for the RAM port arbiter.
// Holds FSM states, access opcodes, size and legality helpers.
package mem_port_arbiter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_MOC,
        ST_COMPLETE,
        ST_FAULT
    } state_e;

    typedef enum logic {
        OWN_IF,
        OWN_LS
    } owner_e;

    localparam logic [5:0] OP_LW = 6'b100011;
    localparam logic [5:0] OP_LH = 6'b100001;
    localparam logic [5:0] OP_LB = 6'b100000;
    localparam logic [5:0] OP_SW = 6'b101011;
    localparam logic [5:0] OP_SH = 6'b101001;
    localparam logic [5:0] OP_SB = 6'b101000;

    // Bytes moved by an access; unknown codes count as one byte.
    function automatic logic [2:0] acc_size(input logic [5:0] op);
        logic [2:0] sz;
        unique case (op)
            OP_LW, OP_SW: sz = 3'd4;
            OP_LH, OP_SH: sz = 3'd2;
            default:      sz = 3'd1;
        endcase
        return sz;
    endfunction

    function automatic logic op_legal(input logic [5:0] op);
        return (op == OP_LW) || (op == OP_LH) || (op == OP_LB) ||
               (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
    endfunction

endpackage

// File: rtl/mem_access_check.sv
// Combinational legality, alignment and range check for one access.
// The last byte touched must lie below MEM_BYTES.
module mem_access_check
    import mem_port_arbiter_pkg::*;
#(
    parameter int MEM_BYTES = 512
) (
    input  logic [5:0]  op_i,
    input  logic [31:0] addr_i,
    output logic        legal_o,
    output logic        aligned_o,
    output logic        in_range_o
);

    logic [2:0]  size;
    logic [32:0] last;

    assign size    = acc_size(op_i);
    assign legal_o = op_legal(op_i);
    assign last    = {1'b0, addr_i} + {30'd0, size} - 33'd1;

    // Wider accesses need their low address bits clear.
    always_comb begin
        aligned_o  = 1'b1;
        in_range_o = (last < 33'(MEM_BYTES));
        unique case (size)
            3'd4:    aligned_o = (addr_i[1:0] == 2'b00);
            3'd2:    aligned_o = (addr_i[0] == 1'b0);
            default: aligned_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single-port RAM between fetch (IF) and load/store (LS).
// Define MEM_TIMEOUT_EN to fault accesses whose MOC never arrives.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int MEM_BYTES   = 512,
    parameter int STARVE_MAX  = 2,
    parameter int TIMEOUT_CYC = 15
) (
    input  logic        Clk,
    input  logic        Clr,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_done,
    output logic [31:0] if_rdata,
    input  logic        ls_req,
    input  logic [5:0]  ls_op,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    output logic        ls_done,
    output logic [31:0] ls_rdata,
    output logic        fault,
    output logic        mem_mov,
    output logic        mem_rw,
    output logic [5:0]  mem_op,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_moc
);

    localparam int SC_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [SC_W-1:0] STARVE_LIM = SC_W'(STARVE_MAX);

    state_e          state_q, state_d;
    owner_e          owner_q, owner_d;
    logic [5:0]      op_q, op_d;
    logic [31:0]     addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic            rw_q, rw_d;
    logic [SC_W-1:0] starve_q, starve_d;
    logic [31:0]     if_rdata_q, if_rdata_d;
    logic [31:0]     ls_rdata_q, ls_rdata_d;

`ifdef MEM_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
    logic [TMO_W-1:0] tmo_q, tmo_d;
`endif

    logic        if_forced;
    logic        grant_ls;
    logic        grant_any;
    logic [5:0]  sel_op;
    logic [31:0] sel_addr;
    logic        chk_legal;
    logic        chk_aligned;
    logic        chk_in_range;

    // IF wins only once LS has been granted STARVE_MAX times in a row.
    assign if_forced = if_req && (starve_q == STARVE_LIM);
    assign grant_ls  = ls_req && !if_forced;
    assign grant_any = ls_req || if_req;
    assign sel_op    = grant_ls ? ls_op : OP_LW;
    assign sel_addr  = grant_ls ? ls_addr : if_addr;

    mem_access_check #(
        .MEM_BYTES (MEM_BYTES)
    ) u_check (
        .op_i       (sel_op),
        .addr_i     (sel_addr),
        .legal_o    (chk_legal),
        .aligned_o  (chk_aligned),
        .in_range_o (chk_in_range)
    );

    // State and datapath registers; reset aborts any access in flight.
    always_ff @(posedge Clk or negedge Clr) begin
        if (!Clr) begin
            state_q    <= ST_IDLE;
            owner_q    <= OWN_IF;
            op_q       <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rw_q       <= 1'b0;
            starve_q   <= '0;
            if_rdata_q <= '0;
            ls_rdata_q <= '0;
`ifdef MEM_TIMEOUT_EN
            tmo_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            op_q       <= op_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rw_q       <= rw_d;
            starve_q   <= starve_d;
            if_rdata_q <= if_rdata_d;
            ls_rdata_q <= ls_rdata_d;
`ifdef MEM_TIMEOUT_EN
            tmo_q      <= tmo_d;
`endif
        end
    end

    // Next-state: arbitrate and check in IDLE, then run the MOV/MOC handshake.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        op_d       = op_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rw_d       = rw_q;
        starve_d   = starve_q;
        if_rdata_d = if_rdata_q;
        ls_rdata_d = ls_rdata_q;
`ifdef MEM_TIMEOUT_EN
        tmo_d      = '0;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (!if_req) begin
                    starve_d = '0;
                end
                if (grant_any) begin
                    owner_d = grant_ls ? OWN_LS : OWN_IF;
                    op_d    = sel_op;
                    addr_d  = sel_addr;
                    wdata_d = grant_ls ? ls_wdata : 32'd0;
                    rw_d    = ~sel_op[3];
                    if (!grant_ls) begin
                        starve_d = '0;
                    end else if (if_req) begin
                        starve_d = starve_q + 1'b1;
                    end
                    if (chk_legal && chk_aligned && chk_in_range) begin
                        state_d = ST_ISSUE;
                    end else begin
                        state_d = ST_FAULT;
                    end
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT_MOC;
            end
            ST_WAIT_MOC: begin
                if (mem_moc) begin
                    if (rw_q && owner_q == OWN_IF) begin
                        if_rdata_d = mem_rdata;
                    end
                    if (rw_q && owner_q == OWN_LS) begin
                        ls_rdata_d = mem_rdata;
                    end
                    state_d = ST_COMPLETE;
                end
`ifdef MEM_TIMEOUT_EN
                else if (tmo_q == TMO_LAST) begin
                    state_d = ST_FAULT;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
`endif
            end
            ST_COMPLETE: begin
                state_d = ST_IDLE;
            end
            ST_FAULT: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign mem_mov   = (state_q == ST_ISSUE) || (state_q == ST_WAIT_MOC);
    assign mem_rw    = rw_q;
    assign mem_op    = op_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign fault     = (state_q == ST_FAULT);
    assign if_done   = ((state_q == ST_COMPLETE) || fault) && (owner_q == OWN_IF);
    assign ls_done   = ((state_q == ST_COMPLETE) || fault) && (owner_q == OWN_LS);
    assign if_rdata  = if_rdata_q;
    assign ls_rdata  = ls_rdata_q;

endmodule
